// File: rtl/seq_mag_comp_if.sv
// Handshake bundle for the digit-serial magnitude comparator: the operand/cascade
// request side and the result/cycle-count response side.
interface seq_mag_comp_if #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             lt_in;
  logic             gt_in;
  logic             eq_in;
  logic             out_valid;
  logic             out_ready;
  logic             lt;
  logic             gt;
  logic             eq;
  logic [CW-1:0]    ncyc;

  modport master (
    output in_valid, a, b, signed_mode, lt_in, gt_in, eq_in, out_ready,
    input  in_ready, out_valid, lt, gt, eq, ncyc
  );

  modport slave (
    input  in_valid, a, b, signed_mode, lt_in, gt_in, eq_in, out_ready,
    output in_ready, out_valid, lt, gt, eq, ncyc
  );
endinterface

// File: rtl/seq_mag_comp.sv
// Digit-serial magnitude comparator, MSB digit first, with optional early exit
// on the first unequal digit and a lt/gt/eq cascade used when all digits match.
module seq_mag_comp #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  seq_mag_comp_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [2:0]       casc_q;
  logic [CW-1:0]    cnt;
  logic             found, f_lt;

  logic [DIGIT-1:0] da, db, flip;
  logic             first, last, ne, dlt, decide, accept;
  logic             res_lt, res_gt, res_eq;

  assign bus.in_ready = (state == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  // Operands shift left each digit, so the digit under test is always the top one.
  assign first = (cnt == '0);
  assign last  = (cnt == CW'(NDIG - 1));

  always_comb begin
    flip            = '0;
    flip[DIGIT-1]   = sgn_q & first;
    da              = a_q[WIDTH-1 -: DIGIT] ^ flip;
    db              = b_q[WIDTH-1 -: DIGIT] ^ flip;
    ne              = (da != db);
    dlt             = (da < db);
    decide          = last || (ne && !found && (EARLY_EXIT != 0));
    res_lt          = casc_q[2];
    res_gt          = casc_q[1];
    res_eq          = casc_q[0];
    if (found) begin
      res_lt = f_lt;
      res_gt = !f_lt;
      res_eq = 1'b0;
    end else if (ne) begin
      res_lt = dlt;
      res_gt = !dlt;
      res_eq = 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (decide) state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.lt        <= 1'b0;
      bus.gt        <= 1'b0;
      bus.eq        <= 1'b0;
      bus.ncyc      <= '0;
      a_q           <= '0;
      b_q           <= '0;
      sgn_q         <= 1'b0;
      casc_q        <= '0;
      cnt           <= '0;
      found         <= 1'b0;
      f_lt          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          a_q    <= bus.a;
          b_q    <= bus.b;
          sgn_q  <= bus.signed_mode;
          casc_q <= {bus.lt_in, bus.gt_in, bus.eq_in};
          cnt    <= '0;
          found  <= 1'b0;
        end
        RUN: begin
          a_q <= a_q << DIGIT;
          b_q <= b_q << DIGIT;
          cnt <= cnt + 1'b1;
          // Only the first unequal digit counts; later digits never override it.
          if (ne && !found) begin
            found <= 1'b1;
            f_lt  <= dlt;
          end
          if (decide) begin
            bus.out_valid <= 1'b1;
            bus.lt        <= res_lt;
            bus.gt        <= res_gt;
            bus.eq        <= res_eq;
            bus.ncyc      <= cnt + 1'b1;
          end
        end
        DONE: if (bus.out_ready) bus.out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule
